// File: rtl/lc3b_regfile_if.sv
// Register-file access bundle: write port, condition-code load, two read ports and NZP flags.
interface lc3b_regfile_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic             LD_REG;
  logic [AW-1:0]    DR;
  logic [WIDTH-1:0] BUS;
  logic             LD_CC;
  logic [AW-1:0]    SR1;
  logic [AW-1:0]    SR2;
  logic [WIDTH-1:0] SR1OUT;
  logic [WIDTH-1:0] SR2OUT;
  logic             N;
  logic             Z;
  logic             P;

  modport master (
    output LD_REG, DR, BUS, LD_CC, SR1, SR2,
    input  SR1OUT, SR2OUT, N, Z, P
  );

  modport slave (
    input  LD_REG, DR, BUS, LD_CC, SR1, SR2,
    output SR1OUT, SR2OUT, N, Z, P
  );
endinterface

// File: rtl/lc3b_regfile.sv
// LC-3b R0-R7 register file with NZP flags; writes land on the rising edge, reads are combinational.
// Optional REGFILE_BYPASS_EN macro forwards BUS to a read port addressing the register being written.
module lc3b_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic           CLK,
  input logic           RESET_N,
  lc3b_regfile_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       nzp_q;
  logic [2:0]       nzp_d;
  logic [WIDTH-1:0] sr1_out;
  logic [WIDTH-1:0] sr2_out;

  always_comb begin
    regs_d = regs_q;
    nzp_d  = nzp_q;
    if (rf.LD_REG) begin
      regs_d[rf.DR] = rf.BUS;
    end
    if (rf.LD_CC) begin
      nzp_d = {rf.BUS[WIDTH-1],
               (rf.BUS == '0),
               ~rf.BUS[WIDTH-1] & (rf.BUS != '0)};
    end
  end

  // Reset wins over any write or flag load presented on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      nzp_q <= 3'b010;
    end else begin
      regs_q <= regs_d;
      nzp_q  <= nzp_d;
    end
  end

  always_comb begin
    sr1_out = regs_q[rf.SR1];
    sr2_out = regs_q[rf.SR2];
`ifdef REGFILE_BYPASS_EN
    // Forward only when the write will actually commit at the coming edge.
    if (RESET_N && rf.LD_REG && (rf.DR == rf.SR1)) begin
      sr1_out = rf.BUS;
    end
    if (RESET_N && rf.LD_REG && (rf.DR == rf.SR2)) begin
      sr2_out = rf.BUS;
    end
`else
    sr1_out = regs_q[rf.SR1];
    sr2_out = regs_q[rf.SR2];
`endif
  end

  assign rf.SR1OUT = sr1_out;
  assign rf.SR2OUT = sr2_out;
  assign rf.N      = nzp_q[2];
  assign rf.Z      = nzp_q[1];
  assign rf.P      = nzp_q[0];

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;
endmodule

// File: tb/tb_lc3b_regfile.sv
// Directed-vector bench for lc3b_regfile: reset, write/read, NZP, read-during-write, reset priority, sweep.
module tb_lc3b_regfile;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lc3b_regfile_if #(.WIDTH(16), .NREGS(8)) rf_if ();

  lc3b_regfile #(.WIDTH(16), .NREGS(8)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .rf      (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_rdw;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    rf_if.LD_REG = 1'b0;
    rf_if.DR     = 3'd0;
    rf_if.BUS    = 16'h0000;
    rf_if.LD_CC  = 1'b0;
    rf_if.SR1    = 3'd0;
    rf_if.SR2    = 3'd0;
    tick();
    rst_n = 1'b1;

    // 1. Reset state
    for (int i = 0; i < 8; i++) begin
      rf_if.SR1 = 3'(i);
      rf_if.SR2 = 3'(7 - i);
      #1;
      check($sformatf("reset_sr1_r%0d", i), rf_if.SR1OUT, 16'h0000);
      check($sformatf("reset_sr2_r%0d", 7 - i), rf_if.SR2OUT, 16'h0000);
    end
    check("reset_nzp", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0002);

    // 2. Write and read back
    rf_if.LD_REG = 1'b1;
    rf_if.DR     = 3'd3;
    rf_if.BUS    = 16'h1234;
    tick();
    rf_if.LD_REG = 1'b0;
    rf_if.SR1    = 3'd3;
    rf_if.SR2    = 3'd3;
    #1;
    check("wr_r3_sr1", rf_if.SR1OUT, 16'h1234);
    check("wr_r3_sr2", rf_if.SR2OUT, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        rf_if.SR1 = 3'(i);
        #1;
        check($sformatf("wr_other_r%0d", i), rf_if.SR1OUT, 16'h0000);
      end
    end
    rf_if.DR  = 3'd3;
    rf_if.BUS = 16'hFFFF;
    rf_if.SR1 = 3'd3;
    tick();
    check("no_ld_reg_hold", rf_if.SR1OUT, 16'h1234);
    check("no_ld_cc_hold", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0002);

    // 3. Condition codes
    rf_if.LD_CC = 1'b1;
    rf_if.BUS   = 16'h8000;
    tick();
    check("cc_neg", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0004);
    rf_if.BUS = 16'h0000;
    tick();
    check("cc_zero", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0002);
    rf_if.BUS = 16'h7FFF;
    tick();
    check("cc_pos", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0001);
    rf_if.BUS = 16'h0001;
    tick();
    check("cc_pos_one", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0001);
    rf_if.LD_CC = 1'b0;
    rf_if.BUS   = 16'h8000;
    tick();
    check("cc_hold", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0001);
    check("cc_no_reg_side_effect", rf_if.SR1OUT, 16'h1234);

    // 4. Read during write
    rf_if.LD_REG = 1'b1;
    rf_if.DR     = 3'd5;
    rf_if.BUS    = 16'hAAAA;
    tick();
    rf_if.BUS = 16'h5555;
    rf_if.SR1 = 3'd5;
    rf_if.SR2 = 3'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_rdw = 16'h5555;
`else
    exp_rdw = 16'hAAAA;
`endif
    check("rdw_same_cycle", rf_if.SR1OUT, exp_rdw);
    check("rdw_other_port", rf_if.SR2OUT, 16'h0000);
    tick();
    rf_if.LD_REG = 1'b0;
    #1;
    check("rdw_after_edge", rf_if.SR1OUT, 16'h5555);
    rf_if.BUS = 16'h0F0F;
    rf_if.DR  = 3'd5;
    #1;
    check("no_fwd_without_ld", rf_if.SR1OUT, 16'h5555);

    // 5. Reset priority
    rf_if.LD_REG = 1'b1;
    rf_if.LD_CC  = 1'b1;
    rf_if.DR     = 3'd2;
    rf_if.BUS    = 16'hBEEF;
    tick();
    rf_if.LD_REG = 1'b0;
    rf_if.LD_CC  = 1'b0;
    rf_if.SR1    = 3'd2;
    #1;
    check("pre_rst_r2", rf_if.SR1OUT, 16'hBEEF);
    check("pre_rst_nzp", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0004);
    rst_n        = 1'b0;
    rf_if.LD_REG = 1'b1;
    rf_if.LD_CC  = 1'b1;
    rf_if.DR     = 3'd2;
    rf_if.BUS    = 16'h9111;
    #1;
    check("rst_no_fwd", rf_if.SR1OUT, 16'hBEEF);
    tick();
    rst_n        = 1'b1;
    rf_if.LD_REG = 1'b0;
    rf_if.LD_CC  = 1'b0;
    rf_if.SR2    = 3'd5;
    #1;
    check("rst_r2_cleared", rf_if.SR1OUT, 16'h0000);
    check("rst_r5_cleared", rf_if.SR2OUT, 16'h0000);
    check("rst_nzp", {13'd0, rf_if.N, rf_if.Z, rf_if.P}, 16'h0002);

    // 6. Back-to-back writes to every register
    rf_if.LD_REG = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rf_if.DR  = 3'(i);
      rf_if.BUS = 16'(16'h0101 * i);
      tick();
    end
    rf_if.LD_REG = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf_if.SR1 = 3'(i);
      rf_if.SR2 = 3'(7 - i);
      #1;
      check($sformatf("sweep_sr1_r%0d", i), rf_if.SR1OUT, 16'(16'h0101 * i));
      check($sformatf("sweep_sr2_r%0d", 7 - i), rf_if.SR2OUT, 16'(16'h0101 * (7 - i)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
